// File: rtl/i2s_audio_in.sv
// i2s_audio_in: I2S master receiver for a 24-bit MEMS microphone (64 sck per frame).
// Generates sck/ws from clk, shifts sd in MSB first and emits one truncated signed
// sample per channel per frame.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sck          I2S bit clock to the mic
//   ws           word select, 0 = left, 1 = right
//   sd           serial data from the mic (asynchronous to clk)
//   sample       signed sample, top w_out bits of the captured word
//   sample_valid one-clk pulse, sample/sample_right valid
//   sample_right channel of the current sample
//   level        peak level meter (tied to 0 unless I2S_RX_LEVEL_EN is defined)
//
// Optional feature macro: I2S_RX_LEVEL_EN enables the decaying peak level meter.

module i2s_audio_in #(
  parameter int clk_mhz     = 27,
  parameter int half_period = 4,
  parameter int w_sample    = 24,
  parameter int w_out       = 16,
  parameter int level_decay = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         sck,
  output logic                         ws,
  input  logic                         sd,
  output logic signed [w_out-1:0]      sample,
  output logic                         sample_valid,
  output logic                         sample_right,
  output logic [$clog2(w_out+1)-1:0]   level
);

  localparam int dw = $clog2(half_period);
  localparam int lw = $clog2(w_out + 1);

  if (half_period < 3 || w_out > w_sample || w_sample > 31 || clk_mhz < 1) begin : g_param_check
    $error("i2s_audio_in: illegal parameter combination");
  end

  logic [dw-1:0]       div_cnt;
  logic [5:0]          bit_cnt;
  logic                sd_meta;
  logic                sd_sync;
  logic                rise_d1;
  logic                cap_evt;
  logic [w_sample-2:0] shift;

  logic                div_tc;
  logic                rise_evt;
  logic                fall_evt;
  logic [5:0]          bit_inc;
  logic [4:0]          p;
  logic                in_window;
  logic                last_bit;
  logic [w_sample-1:0] shift_next;

  assign div_tc     = (div_cnt == dw'(half_period - 1));
  assign rise_evt   = div_tc & ~sck;
  assign fall_evt   = div_tc & sck;
  assign bit_inc    = bit_cnt + 6'd1;
  assign p          = bit_cnt[4:0];
  // p=0 is the slot right after the ws edge; bits past w_sample are tri-stated by the mic
  assign in_window  = (p != 5'd0) && (p <= 5'(w_sample));
  assign last_bit   = (p == 5'(w_sample));
  assign shift_next = {shift, sd_sync};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      sck          <= 1'b0;
      bit_cnt      <= '0;
      ws           <= 1'b0;
      sd_meta      <= 1'b0;
      sd_sync      <= 1'b0;
      rise_d1      <= 1'b0;
      cap_evt      <= 1'b0;
      shift        <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      sample_right <= 1'b0;
    end else begin
      div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
      if (div_tc) sck <= ~sck;
      if (fall_evt) begin
        bit_cnt <= bit_inc;
        ws      <= bit_inc[5];
      end
      sd_meta <= sd;
      sd_sync <= sd_meta;
      // capture waits two clk after the rising edge to cover the synchroniser delay
      rise_d1 <= rise_evt;
      cap_evt <= rise_d1;
      sample_valid <= 1'b0;
      if (cap_evt && in_window) shift <= shift_next[w_sample-2:0];
      if (cap_evt && last_bit) begin
        sample       <= shift_next[w_sample-1 -: w_out];
        sample_right <= ws;
        sample_valid <= 1'b1;
      end
    end
  end

`ifdef I2S_RX_LEVEL_EN
  localparam int cw = $clog2(level_decay + 1);

  logic [cw-1:0]    decay_cnt;
  logic [w_out-1:0] raw;
  logic [w_out-1:0] mag;
  logic [lw-1:0]    lvl_new;
  logic [lw-1:0]    lvl_dec;

  // unsigned magnitude: the most negative value maps to 2^(w_out-1) without overflow
  always_comb begin
    raw     = sample;
    mag     = raw[w_out-1] ? (~raw + 1'b1) : raw;
    lvl_new = '0;
    for (int i = 0; i < w_out; i++) begin
      if (mag[i]) lvl_new = lw'(i + 1);
    end
    lvl_dec = (level == '0) ? '0 : level - 1'b1;
    if (lvl_new > lvl_dec) lvl_dec = lvl_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level     <= '0;
      decay_cnt <= '0;
    end else if (sample_valid) begin
      if (lvl_new > level) begin
        level     <= lvl_new;
        decay_cnt <= '0;
      end else if (decay_cnt == cw'(level_decay - 1)) begin
        level     <= lvl_dec;
        decay_cnt <= '0;
      end else begin
        decay_cnt <= decay_cnt + 1'b1;
      end
    end
  end
`else
  assign level = '0;
`endif

endmodule
